// File: rtl/param_alu_if.sv
// param_alu_if: request/result bundle between the front end and param_alu_core
interface param_alu_if #(parameter int WIDTH = 8);
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] y_out;
  logic [3:0]       flags;
  logic             busy;
  logic             done;
  logic             err;
  modport master (output start, op, din, input a_out, b_out, y_out, flags, busy, done, err);
  modport slave  (input start, op, din, output a_out, b_out, y_out, flags, busy, done, err);
endinterface

// File: rtl/param_alu_core.sv
// param_alu_core: A/B/Y register ALU with N/Z/C/V flags and a WIDTH-cycle signed shift-add multiply
module param_alu_core #(parameter int WIDTH = 8) (
  input logic         clk,
  input logic         reset_n,
  param_alu_if.slave  bus
);
  localparam int W = WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nx;
  logic [W-1:0] a, b, y, res, add_s, sub_s, mplr;
  logic [3:0] flg, mflg;
  logic [2*W-1:0] acc, acc_nx, mcand, addend;
  logic [CW-1:0] cnt;
  logic done_q, err_q, add_c, sub_b, c, v, wy, last;
  assign {add_c, add_s} = {1'b0, a} + {1'b0, b};
  assign {sub_b, sub_s} = {1'b0, a} - {1'b0, b};
  assign last = cnt == LAST;
  always_comb begin
    res = '0;
    c = 1'b0;
    v = 1'b0;
    wy = 1'b1;
    case (bus.op)
      5'd0: begin
        res = add_s;
        c = add_c;
        v = (a[W-1] == b[W-1]) && (add_s[W-1] != a[W-1]);
      end
      5'd1: begin
        res = sub_s;
        c = ~sub_b;
        v = (a[W-1] != b[W-1]) && (sub_s[W-1] != a[W-1]);
      end
      5'd2: begin
        res = {a[W-2:0], 1'b0};
        c = a[W-1];
      end
      5'd3: begin
        res = {a[W-1], a[W-1:1]};
        c = a[0];
      end
      5'd4: res = (a == b) ? '0 : ($signed(a) > $signed(b)) ? W'(1) : '1;
      5'd5: res = a & b;
      5'd6: res = a | b;
      5'd7: res = a ^ b;
      5'd8: res = ~(a & b);
      5'd9: res = ~(a | b);
      5'd10: res = ~(a ^ b);
      5'd11: res = ~a;
      5'd12: begin
        res = -a;
        v = a == {1'b1, {(W-1){1'b0}}};
      end
      default: wy = 1'b0;
    endcase
  end
  // The MSB partial product carries negative weight, so the final step subtracts
  always_comb begin
    addend = mplr[0] ? mcand : '0;
    acc_nx = last ? acc - addend : acc + addend;
    mflg = {acc_nx[W-1], acc_nx[W-1:0] == '0, 1'b0, acc_nx[2*W-1:W-1] != {(W+1){acc_nx[W-1]}}};
    state_nx = (state == IDLE) ? ((bus.start && bus.op == 5'd16) ? MUL : IDLE) : (last ? IDLE : MUL);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      y <= '0;
      flg <= '0;
      acc <= '0;
      mcand <= '0;
      mplr <= '0;
      cnt <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      done_q <= 1'b0;
      err_q <= 1'b0;
      if (state == MUL) begin
        acc <= acc_nx;
        mcand <= {mcand[2*W-2:0], 1'b0};
        mplr <= mplr >> 1;
        cnt <= cnt + 1'b1;
        if (last) begin
          y <= acc_nx[W-1:0];
          flg <= mflg;
          done_q <= 1'b1;
          cnt <= '0;
        end
      end else if (bus.start) begin
        if (bus.op > 5'd17) err_q <= 1'b1;
        else begin
          done_q <= bus.op != 5'd16;
          if (bus.op == 5'd16) begin
            acc <= '0;
            mcand <= {{W{a[W-1]}}, a};
            mplr <= b;
            cnt <= '0;
          end
          if (wy) begin
            y <= res;
            flg <= {res[W-1], res == '0, c, v};
          end
          case (bus.op)
            5'd13: a <= y;
            5'd14: begin
              a <= b;
              b <= a;
            end
            5'd15: a <= bus.din;
            5'd17: b <= bus.din;
            default: ;
          endcase
        end
      end
    end
  end
  assign bus.a_out = a;
  assign bus.b_out = b;
  assign bus.y_out = y;
  assign bus.flags = flg;
  assign bus.busy = state == MUL;
  assign bus.done = done_q;
  assign bus.err = err_q;
endmodule
